// File: rtl/blut_pkg.sv
// rtl/blut_pkg.sv - shared constants and types for the BLUT sequencer
package blut_pkg;

    localparam int NUM_ENTRIES = 32;
    localparam int IDX_W       = 5;
    localparam int ADDR_W      = 10;

    typedef enum logic [1:0] {IDLE, INIT, RUN} blut_seq_state_t;

    typedef enum {GNT_NONE, GNT_LK, GNT_CFG} blut_gnt_t;

endpackage

// File: rtl/blut_arbiter.sv
// rtl/blut_arbiter.sv - lookup vs config-write grant with bounded write deferral
module blut_arbiter
    import blut_pkg::*;
#(
    parameter int MAX_DEFER = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      i_en,
    input  logic      i_lk_req,
    input  logic      i_cfg_valid,
    output blut_gnt_t o_gnt
);

    localparam int DEF_W = $clog2(MAX_DEFER + 1);

    logic [DEF_W-1:0] r_defer;
    logic             w_defer_full;

    assign w_defer_full = (r_defer == DEF_W'(MAX_DEFER));

    always_comb begin
        o_gnt = GNT_NONE;
        if (i_en) begin
            if (i_lk_req && i_cfg_valid) begin
                o_gnt = w_defer_full ? GNT_CFG : GNT_LK;
            end else if (i_lk_req) begin
                o_gnt = GNT_LK;
            end else if (i_cfg_valid) begin
                o_gnt = GNT_CFG;
            end
        end
    end

    // Counts only cycles where a waiting write actually lost to a lookup.
    always_ff @(posedge clk) begin
        if (reset || !i_en) begin
            r_defer <= '0;
        end else if (o_gnt == GNT_CFG || !i_cfg_valid) begin
            r_defer <= '0;
        end else if (o_gnt == GNT_LK) begin
            r_defer <= r_defer + 1'b1;
        end
    end

endmodule

// File: rtl/blut_sequencer.sv
// rtl/blut_sequencer.sv - BLUT port owner: post-reset table init, then lookup/config arbitration
module blut_sequencer
    import blut_pkg::*;
#(
    parameter int MAX_DEFER = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_valid,
    input  logic [ADDR_W-1:0] init_target,
    output logic              init_ready,
    output logic              init_done,
    input  logic              lk_req,
    input  logic [IDX_W-1:0]  lk_index,
    output logic              lk_ready,
    output logic              lk_rsp_valid,
    output logic [ADDR_W-1:0] lk_target,
    input  logic              cfg_valid,
    input  logic [IDX_W-1:0]  cfg_index,
    input  logic [ADDR_W-1:0] cfg_target,
    output logic              cfg_ready,
    output logic [IDX_W-1:0]  blut_index,
    output logic [ADDR_W-1:0] blut_target_address,
    output logic              blut_write_enable,
    input  logic [ADDR_W-1:0] blut_branch_target
);

    blut_seq_state_t r_state;
    blut_seq_state_t w_next_state;
    blut_gnt_t       w_gnt;

    logic [IDX_W-1:0] r_init_cnt;
    logic [IDX_W-1:0] r_last_index;
    logic             r_lk_rsp_valid;
    logic             w_init_beat;
    logic             w_run;

    assign w_run       = (r_state == RUN);
    assign w_init_beat = (r_state == INIT) && init_valid;

    blut_arbiter #(
        .MAX_DEFER (MAX_DEFER)
    ) u_arbiter (
        .clk         (clk),
        .reset       (reset),
        .i_en        (w_run),
        .i_lk_req    (lk_req),
        .i_cfg_valid (cfg_valid),
        .o_gnt       (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = INIT;
            INIT:    if (w_init_beat && r_init_cnt == IDX_W'(NUM_ENTRIES - 1)) w_next_state = RUN;
            RUN:     w_next_state = RUN;
            default: w_next_state = IDLE;
        endcase
    end

    // Index holds its previous value when nothing is granted, so the BLUT
    // output register keeps re-reading the same entry on idle cycles.
    always_comb begin
        init_ready          = (r_state == INIT);
        init_done           = w_run;
        lk_ready            = (w_gnt == GNT_LK);
        cfg_ready           = (w_gnt == GNT_CFG);
        blut_write_enable   = 1'b0;
        blut_index          = r_last_index;
        blut_target_address = '0;
        if (w_init_beat) begin
            blut_write_enable   = 1'b1;
            blut_index          = r_init_cnt;
            blut_target_address = init_target;
        end else if (w_gnt == GNT_CFG) begin
            blut_write_enable   = 1'b1;
            blut_index          = cfg_index;
            blut_target_address = cfg_target;
        end else if (w_gnt == GNT_LK) begin
            blut_index          = lk_index;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_init_cnt     <= '0;
            r_last_index   <= '0;
            r_lk_rsp_valid <= 1'b0;
        end else begin
            if (w_init_beat) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
            r_last_index   <= blut_index;
            r_lk_rsp_valid <= (w_gnt == GNT_LK);
        end
    end

    assign lk_rsp_valid = r_lk_rsp_valid;
    assign lk_target    = blut_branch_target;

endmodule

// File: tb/tb_blut_sequencer.sv
// tb/tb_blut_sequencer.sv - directed table-driven bench for blut_sequencer
module tb_blut_sequencer;
    import blut_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              init_valid, init_ready, init_done;
    logic [ADDR_W-1:0] init_target;
    logic              lk_req, lk_ready, lk_rsp_valid;
    logic [IDX_W-1:0]  lk_index;
    logic [ADDR_W-1:0] lk_target;
    logic              cfg_valid, cfg_ready;
    logic [IDX_W-1:0]  cfg_index;
    logic [ADDR_W-1:0] cfg_target;
    logic [IDX_W-1:0]  blut_index;
    logic [ADDR_W-1:0] blut_target_address;
    logic              blut_write_enable;
    logic [ADDR_W-1:0] blut_branch_target;

    always #5 clk = ~clk;

    blut_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .init_valid          (init_valid),
        .init_target         (init_target),
        .init_ready          (init_ready),
        .init_done           (init_done),
        .lk_req              (lk_req),
        .lk_index            (lk_index),
        .lk_ready            (lk_ready),
        .lk_rsp_valid        (lk_rsp_valid),
        .lk_target           (lk_target),
        .cfg_valid           (cfg_valid),
        .cfg_index           (cfg_index),
        .cfg_target          (cfg_target),
        .cfg_ready           (cfg_ready),
        .blut_index          (blut_index),
        .blut_target_address (blut_target_address),
        .blut_write_enable   (blut_write_enable),
        .blut_branch_target  (blut_branch_target)
    );

    // BLUT behavioural model: write array and registered read at the same edge.
    logic [ADDR_W-1:0] mem [NUM_ENTRIES];
    always @(posedge clk) begin
        if (reset) blut_branch_target <= '0;
        else       blut_branch_target <= mem[blut_index];
        if (blut_write_enable) mem[blut_index] <= blut_target_address;
    end

    int checks = 0;
    int failures = 0;
    int beats, done_cyc, last_cyc, bad_ready, bad_idx;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams base+i into the init port starting in the first cycle after reset release.
    task automatic run_init(input logic [ADDR_W-1:0] base, input bit bubbles, input int abort_at);
        beats = 0; done_cyc = 0; last_cyc = 0; bad_ready = 0; bad_idx = 0;
        init_valid  = !bubbles;
        init_target = base;
        for (int c = 1; c <= 150; c++) begin
            #4;
            if (init_done) begin
                done_cyc = c;
                return;
            end
            if (lk_ready || cfg_ready) bad_ready++;
            if (init_ready && init_valid) begin
                if (!blut_write_enable || blut_index != beats[IDX_W-1:0] ||
                    blut_target_address != base + ADDR_W'(beats)) bad_idx++;
                beats++;
                last_cyc = c;
            end else if (blut_write_enable) begin
                bad_idx++;
            end
            tick();
            if (abort_at >= 0 && beats == abort_at) return;
            if (bubbles) init_valid = !init_valid;
            init_target = base + ADDR_W'(beats);
        end
    endtask

    typedef struct {
        logic              lk;
        logic [IDX_W-1:0]  lki;
        logic              cfg;
        logic [IDX_W-1:0]  ci;
        logic [ADDR_W-1:0] ct;
        logic              e_lr;
        logic              e_cr;
        logic              e_we;
        logic [IDX_W-1:0]  e_idx;
        logic [ADDR_W-1:0] e_ta;
        logic              e_rsp;
        logic [ADDR_W-1:0] e_tgt;
    } vec_t;

    function automatic vec_t mk(input logic lk, input logic [IDX_W-1:0] lki,
                                input logic cfg, input logic [IDX_W-1:0] ci, input logic [ADDR_W-1:0] ct,
                                input logic lr, input logic cr, input logic we,
                                input logic [IDX_W-1:0] idx, input logic [ADDR_W-1:0] ta,
                                input logic rsp, input logic [ADDR_W-1:0] tgt);
        vec_t v;
        v.lk = lk; v.lki = lki; v.cfg = cfg; v.ci = ci; v.ct = ct;
        v.e_lr = lr; v.e_cr = cr; v.e_we = we; v.e_idx = idx; v.e_ta = ta;
        v.e_rsp = rsp; v.e_tgt = tgt;
        return v;
    endfunction

    vec_t tbl [26];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(1, 5'd7,  0, 5'd0, 10'h000, 1, 0, 0, 5'd7,  10'h000, 0, 10'h000);
        tbl[1]  = mk(0, 5'd0,  0, 5'd0, 10'h000, 0, 0, 0, 5'd7,  10'h000, 1, 10'h107);
        tbl[2]  = mk(0, 5'd0,  0, 5'd0, 10'h000, 0, 0, 0, 5'd7,  10'h000, 0, 10'h000);
        tbl[3]  = mk(0, 5'd0,  1, 5'd3, 10'h2AA, 0, 1, 1, 5'd3,  10'h2AA, 0, 10'h000);
        tbl[4]  = mk(1, 5'd3,  0, 5'd0, 10'h000, 1, 0, 0, 5'd3,  10'h000, 0, 10'h000);
        tbl[5]  = mk(1, 5'd10, 0, 5'd0, 10'h000, 1, 0, 0, 5'd10, 10'h000, 1, 10'h2AA);
        tbl[6]  = mk(0, 5'd0,  0, 5'd0, 10'h000, 0, 0, 0, 5'd10, 10'h000, 1, 10'h10A);
        tbl[7]  = mk(1, 5'd20, 0, 5'd0, 10'h000, 1, 0, 0, 5'd20, 10'h000, 0, 10'h000);
        tbl[8]  = mk(0, 5'd0,  0, 5'd0, 10'h000, 0, 0, 0, 5'd20, 10'h000, 1, 10'h114);
        tbl[9]  = mk(0, 5'd0,  0, 5'd0, 10'h000, 0, 0, 0, 5'd20, 10'h000, 0, 10'h000);
        tbl[10] = mk(1, 5'd21, 0, 5'd0, 10'h000, 1, 0, 0, 5'd21, 10'h000, 0, 10'h000);
        tbl[11] = mk(1, 5'd1,  1, 5'd5, 10'h055, 1, 0, 0, 5'd1,  10'h000, 1, 10'h115);
        tbl[12] = mk(1, 5'd1,  1, 5'd5, 10'h055, 1, 0, 0, 5'd1,  10'h000, 1, 10'h101);
        tbl[13] = mk(1, 5'd1,  1, 5'd5, 10'h055, 1, 0, 0, 5'd1,  10'h000, 1, 10'h101);
        tbl[14] = mk(1, 5'd1,  1, 5'd5, 10'h055, 1, 0, 0, 5'd1,  10'h000, 1, 10'h101);
        tbl[15] = mk(1, 5'd1,  1, 5'd5, 10'h055, 0, 1, 1, 5'd5,  10'h055, 1, 10'h101);
        tbl[16] = mk(1, 5'd1,  1, 5'd5, 10'h055, 1, 0, 0, 5'd1,  10'h000, 0, 10'h000);
        tbl[17] = mk(1, 5'd1,  1, 5'd5, 10'h055, 1, 0, 0, 5'd1,  10'h000, 1, 10'h101);
        tbl[18] = mk(1, 5'd5,  0, 5'd0, 10'h000, 1, 0, 0, 5'd5,  10'h000, 1, 10'h101);
        tbl[19] = mk(1, 5'd1,  1, 5'd6, 10'h066, 1, 0, 0, 5'd1,  10'h000, 1, 10'h055);
        tbl[20] = mk(1, 5'd1,  1, 5'd6, 10'h066, 1, 0, 0, 5'd1,  10'h000, 1, 10'h101);
        tbl[21] = mk(1, 5'd1,  1, 5'd6, 10'h066, 1, 0, 0, 5'd1,  10'h000, 1, 10'h101);
        tbl[22] = mk(1, 5'd1,  1, 5'd6, 10'h066, 1, 0, 0, 5'd1,  10'h000, 1, 10'h101);
        tbl[23] = mk(1, 5'd1,  1, 5'd6, 10'h066, 0, 1, 1, 5'd6,  10'h066, 1, 10'h101);
        tbl[24] = mk(1, 5'd6,  0, 5'd0, 10'h000, 1, 0, 0, 5'd6,  10'h000, 0, 10'h000);
        tbl[25] = mk(0, 5'd0,  0, 5'd0, 10'h000, 0, 0, 0, 5'd6,  10'h000, 1, 10'h066);

        init_valid = 0; init_target = '0;
        lk_req = 0; lk_index = '0;
        cfg_valid = 0; cfg_index = '0; cfg_target = '0;
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        #4;
        chk("rst init_ready", init_ready, 0);
        chk("rst init_done", init_done, 0);
        chk("rst lk_ready", lk_ready, 0);
        chk("rst cfg_ready", cfg_ready, 0);
        chk("rst write_enable", blut_write_enable, 0);
        chk("rst lk_rsp_valid", lk_rsp_valid, 0);
        chk("rst blut_index", blut_index, 0);
        chk("rst target_address", blut_target_address, 0);
        tick();

        reset = 0;
        run_init(10'h100, 0, -1);
        chk("init1 done cycle", done_cyc, 34);
        chk("init1 beats", beats, 32);
        chk("init1 bad writes", bad_idx, 0);
        chk("init1 ready during init", bad_ready, 0);
        tick();

        for (int i = 0; i < 26; i++) begin
            lk_req = tbl[i].lk; lk_index = tbl[i].lki;
            cfg_valid = tbl[i].cfg; cfg_index = tbl[i].ci; cfg_target = tbl[i].ct;
            #4;
            chk($sformatf("r%0d lk_ready", i), lk_ready, tbl[i].e_lr);
            chk($sformatf("r%0d cfg_ready", i), cfg_ready, tbl[i].e_cr);
            chk($sformatf("r%0d write_enable", i), blut_write_enable, tbl[i].e_we);
            chk($sformatf("r%0d blut_index", i), blut_index, tbl[i].e_idx);
            chk($sformatf("r%0d lk_rsp_valid", i), lk_rsp_valid, tbl[i].e_rsp);
            if (tbl[i].e_rsp) chk($sformatf("r%0d lk_target", i), lk_target, tbl[i].e_tgt);
            if (tbl[i].e_we) chk($sformatf("r%0d target_address", i), blut_target_address, tbl[i].e_ta);
            tick();
        end

        // Mid-init reset with both requesters held throughout.
        lk_req = 1; lk_index = 5'd3;
        cfg_valid = 1; cfg_index = 5'd9; cfg_target = 10'h3FF;
        reset = 1;
        tick(); tick();
        #4;
        chk("rst2 init_done", init_done, 0);
        chk("rst2 lk_ready", lk_ready, 0);
        chk("rst2 cfg_ready", cfg_ready, 0);
        chk("rst2 lk_rsp_valid", lk_rsp_valid, 0);
        tick();
        reset = 0;
        run_init(10'h200, 1, 15);
        chk("abort beats", beats, 15);
        chk("abort ready during init", bad_ready, 0);
        init_valid = 0;
        reset = 1;
        tick();
        reset = 0;
        run_init(10'h300, 1, -1);
        chk("init2 beats", beats, 32);
        chk("init2 bad writes", bad_idx, 0);
        chk("init2 ready during init", bad_ready, 0);
        chk("init2 done cycle", done_cyc, 65);
        chk("init2 done after last beat", done_cyc, last_cyc + 1);
        chk("init2 first run lk_ready", lk_ready, 1);
        chk("init2 first run cfg_ready", cfg_ready, 0);
        tick();
        lk_req = 0; cfg_valid = 0;
        #4;
        chk("init2 lookup rsp_valid", lk_rsp_valid, 1);
        chk("init2 lookup target", lk_target, 10'h303);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/blut_sequencer.md
Name: blut_sequencer

Overview:
Controller that owns the branch lookup table (BLUT) ports and shares them between the fetch stage, which performs target lookups, and the program loader, which writes targets.
After reset it sequences a full table initialisation from a streamed init source, because BLUT reset clears only its output register and not its contents.
In run mode it arbitrates lookups against config writes, with bounded deferral of writes.
Sits between fetch/PC logic and the BLUT instance.

Parameters:
NUM_ENTRIES, 32, number of BLUT entries (power of two)
IDX_W, 5, index width, log2(NUM_ENTRIES)
ADDR_W, 10, branch target width
MAX_DEFER, 4, max consecutive cycles a pending config write loses to lookups before it is forced

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
init_valid  in  1  init stream word valid
init_target  in  ADDR_W  target for the current init entry (entries arrive in order 0..NUM_ENTRIES-1)
init_ready  out  1  sequencer accepts init word this cycle
init_done  out  1  table fully initialised; run mode
lk_req  in  1  fetch lookup request
lk_index  in  IDX_W  lookup index
lk_ready  out  1  lookup accepted this cycle
lk_rsp_valid  out  1  lookup result valid
lk_target  out  ADDR_W  lookup result
cfg_valid  in  1  config write request
cfg_index  in  IDX_W  config entry
cfg_target  in  ADDR_W  config target value
cfg_ready  out  1  config write accepted this cycle
blut_index  out  IDX_W  to BLUT index
blut_target_address  out  ADDR_W  to BLUT target_address
blut_write_enable  out  1  to BLUT write_enable
blut_branch_target  in  ADDR_W  from BLUT branch_target

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All registered state updates on posedge clk.
- Reset values: state=IDLE; all outputs 0; init counter=0; defer counter=0.
- Reset asserted mid-operation (including mid-INIT) aborts at once. The next INIT restarts at entry 0.
- FSM IDLE: lasts 1 cycle, then INIT unconditionally.
- FSM INIT: init_ready=1.
  - On init_valid&init_ready: blut_write_enable=1, blut_index=counter, blut_target_address=init_target (combinational), counter++.
  - On the beat with counter==NUM_ENTRIES-1: next state RUN, init_done=1 from the next cycle.
  - lk_ready=0 and cfg_ready=0 throughout INIT.
  - init_valid=0 inserts bubbles; blut_write_enable=0 on bubble cycles.
- FSM RUN: init_ready=0, init_done=1. Never leaves RUN except via reset.
- RUN arbitration, each cycle:
  - lk_req only: grant lookup. lk_ready=1, blut_index=lk_index, blut_write_enable=0.
  - cfg_valid only: grant write. cfg_ready=1, blut_write_enable=1, index and target from cfg.
  - Both, defer<MAX_DEFER: grant lookup; defer++.
  - Both, defer==MAX_DEFER: grant write; lk_ready=0, which stalls fetch.
  - defer resets to 0 on any cycle cfg is granted or cfg_valid=0.
  - Neither: blut_write_enable=0; blut_index holds its last value.
- Lookup latency: 1 cycle. lk_rsp_valid is registered and equals the previous cycle's lookup grant. lk_target=blut_branch_target (combinational pass-through).
- lk_rsp_valid=0 in any cycle following a write or idle cycle. In those cycles the BLUT output register holds stale data, and consumers must ignore lk_target.
- Read-after-write: a lookup granted the cycle after a write to the same index returns the new value. No bypass is needed, because BLUT writes at the edge before the read edge.
- Requesters hold their request and data until ready. Dropping a request before ready is legal; no state is retained.
- No combinational path from lk_ready to lk_req or from cfg_ready to cfg_valid.

Decomposition:
- Package blut_pkg:
  - NUM_ENTRIES, IDX_W, ADDR_W constants.
  - typedef enum logic [1:0] {IDLE, INIT, RUN} blut_seq_state_t.
  - typedef enum {GNT_NONE, GNT_LK, GNT_CFG} blut_gnt_t.
- One natural sub-module, blut_arbiter: the two-requester grant logic plus the defer counter, with MAX_DEFER as a parameter.
- The FSM and the init counter stay in the top module.

Test Plan:
- Reset, then stream targets 0x100+i for i=0..31 with no bubbles -> init_done rises on cycle 34 after reset release; a lookup of index 7 then returns 0x107 with lk_rsp_valid 1 cycle later.
- Init with init_valid toggling every other cycle -> only valid beats write; 32 writes total; init_done rises after the 32nd beat; lk_ready=0 and cfg_ready=0 throughout.
- RUN: cfg write index 3 = 0x2AA; next cycle lookup index 3 -> lk_target=0x2AA with lk_rsp_valid=1.
- lk_req and cfg_valid held together continuously -> 4 lookups granted, then 1 cfg grant with lk_ready=0, then lookups resume; defer returns to 0.
- Reset asserted at init entry 15 -> next INIT starts at index 0; init_done=0 until 32 new beats complete.
- Idle cycle between lookups -> lk_rsp_valid=0 in the cycle after the idle cycle; lk_target is ignored.
